// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control FSM and its review scroll timer.
// State encoding doubles as the externally visible mode code.
package stopwatch_ctrl_pkg;

  localparam int MODE_W           = 2;
  localparam int DEF_SCROLL_TICKS = 20;
  localparam int SCROLL_W         = 8;

  typedef enum logic [MODE_W-1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STOP   = 2'b10,
    ST_REVIEW = 2'b11
  } state_t;

endpackage

// File: rtl/stopwatch_ctrl_review_scroll_timer.sv
// Counts timer ticks while reviewing laps; expire is a combinational one-cycle
// flag on the tick that completes SCROLL_TICKS ticks, after which the count restarts.
module review_scroll_timer
  import stopwatch_ctrl_pkg::*;
#(
  parameter int SCROLL_TICKS = DEF_SCROLL_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic tick,
  output logic expire
);

  localparam logic [SCROLL_W-1:0] LAST = SCROLL_W'(SCROLL_TICKS - 1);

  logic [SCROLL_W-1:0] cnt_q;
  logic [SCROLL_W-1:0] cnt_d;

  assign expire = en & tick & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || expire) begin
      cnt_d = '0;
    end else if (en && tick) begin
      cnt_d = cnt_q + SCROLL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing FSM: drives counter enable/clear, lap-memory writes and the
// auto-scrolling review address; all outputs are registered.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 2,
  parameter int SCROLL_TICKS = DEF_SCROLL_TICKS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_stop_p,
  input  logic              lap_p,
  input  logic              show_p,
  input  logic              tick,
  output logic              run,
  output logic              cnt_clr,
  output logic              lap_we,
  output logic [ADDR_W-1:0] lap_waddr,
  output logic [ADDR_W:0]   lap_count,
  output logic              full,
  output logic [ADDR_W-1:0] show_addr,
  output logic              show_valid,
  output logic [MODE_W-1:0] mode
);

  localparam int            MEM_SIZE   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] MEM_SIZE_C = (ADDR_W + 1)'(MEM_SIZE);

  state_t              state_q, state_d;
  logic                run_q, run_d;
  logic                cnt_clr_q, cnt_clr_d;
  logic                lap_we_q, lap_we_d;
  logic [ADDR_W-1:0]   lap_waddr_q, lap_waddr_d;
  logic [ADDR_W:0]     lap_count_q, lap_count_d;
  logic [ADDR_W-1:0]   show_addr_q, show_addr_d;
  logic                show_valid_q, show_valid_d;

  logic scroll_en;
  logic scroll_clr;
  logic scroll_expire;
  logic show_last;

  assign scroll_en = (state_q == ST_REVIEW);
  assign show_last = ({1'b0, show_addr_q} == (lap_count_q - (ADDR_W + 1)'(1)));

  review_scroll_timer #(
    .SCROLL_TICKS(SCROLL_TICKS)
  ) u_scroll (
    .clk    (clk),
    .reset  (reset),
    .en     (scroll_en),
    .clr    (scroll_clr),
    .tick   (tick),
    .expire (scroll_expire)
  );

  always_comb begin
    state_d     = state_q;
    cnt_clr_d   = 1'b0;
    lap_we_d    = 1'b0;
    lap_waddr_d = lap_waddr_q;
    lap_count_d = lap_count_q;
    show_addr_d = show_addr_q;
    scroll_clr  = 1'b0;

    // Button priority: start_stop_p, then lap_p, then show_p.
    unique case (state_q)
      ST_IDLE: begin
        if (start_stop_p) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (start_stop_p) begin
          state_d = ST_STOP;
        end else if (lap_p && (lap_count_q != MEM_SIZE_C)) begin
          lap_we_d    = 1'b1;
          lap_waddr_d = lap_count_q[ADDR_W-1:0];
          lap_count_d = lap_count_q + (ADDR_W + 1)'(1);
        end
      end
      ST_STOP: begin
        if (start_stop_p) begin
          state_d = ST_RUN;
        end else if (lap_p) begin
          state_d     = ST_IDLE;
          cnt_clr_d   = 1'b1;
          lap_count_d = '0;
          show_addr_d = '0;
        end else if (show_p && (lap_count_q != '0)) begin
          state_d     = ST_REVIEW;
          show_addr_d = '0;
          scroll_clr  = 1'b1;
        end
      end
      ST_REVIEW: begin
        if (start_stop_p) begin
          state_d = ST_RUN;
        end else if (lap_p) begin
          state_d = ST_STOP;
        end else if (show_p || scroll_expire) begin
          // A manual advance and an expiring tick together still move by one.
          show_addr_d = show_last ? '0 : show_addr_q + ADDR_W'(1);
          scroll_clr  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    run_d        = (state_d == ST_RUN);
    show_valid_d = (state_d == ST_REVIEW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      run_q        <= 1'b0;
      cnt_clr_q    <= 1'b0;
      lap_we_q     <= 1'b0;
      lap_waddr_q  <= '0;
      lap_count_q  <= '0;
      show_addr_q  <= '0;
      show_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      cnt_clr_q    <= cnt_clr_d;
      lap_we_q     <= lap_we_d;
      lap_waddr_q  <= lap_waddr_d;
      lap_count_q  <= lap_count_d;
      show_addr_q  <= show_addr_d;
      show_valid_q <= show_valid_d;
    end
  end

  assign run        = run_q;
  assign cnt_clr    = cnt_clr_q;
  assign lap_we     = lap_we_q;
  assign lap_waddr  = lap_waddr_q;
  assign lap_count  = lap_count_q;
  assign full       = (lap_count_q == MEM_SIZE_C);
  assign show_addr  = show_addr_q;
  assign show_valid = show_valid_q;
  assign mode       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, directed corner sequences and random
// stimulus against a behavioural model of the button/tick rules.
module tb_stopwatch_ctrl;

  localparam int ADDR_W = 2;
  localparam int NLAPS  = 4;
  localparam int STICKS = 20;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start_stop_p = 1'b0;
  logic              lap_p = 1'b0;
  logic              show_p = 1'b0;
  logic              tick = 1'b0;
  logic              run;
  logic              cnt_clr;
  logic              lap_we;
  logic [ADDR_W-1:0] lap_waddr;
  logic [ADDR_W:0]   lap_count;
  logic              full;
  logic [ADDR_W-1:0] show_addr;
  logic              show_valid;
  logic [1:0]        mode;

  always #10 clk = ~clk;

  stopwatch_ctrl #(.ADDR_W(ADDR_W), .SCROLL_TICKS(STICKS)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_stop_p (start_stop_p),
    .lap_p        (lap_p),
    .show_p       (show_p),
    .tick         (tick),
    .run          (run),
    .cnt_clr      (cnt_clr),
    .lap_we       (lap_we),
    .lap_waddr    (lap_waddr),
    .lap_count    (lap_count),
    .full         (full),
    .show_addr    (show_addr),
    .show_valid   (show_valid),
    .mode         (mode)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- behavioural model ----------------
  string m_state;
  int    m_laps, m_show, m_scroll, m_waddr;
  int    m_we, m_clr;

  function automatic int mode_of(input string s);
    if (s == "RUN")    return 1;
    if (s == "STOP")   return 2;
    if (s == "REVIEW") return 3;
    return 0;
  endfunction

  function automatic void model_reset();
    m_state = "IDLE"; m_laps = 0; m_show = 0; m_scroll = 0;
    m_waddr = 0; m_we = 0; m_clr = 0;
  endfunction

  function automatic void model_step(input bit ss, input bit lp, input bit sh, input bit tk);
    m_we = 0; m_clr = 0;
    if (m_state == "IDLE") begin
      if (ss) m_state = "RUN";
    end else if (m_state == "RUN") begin
      if (ss) m_state = "STOP";
      else if (lp && m_laps < NLAPS) begin
        m_we = 1; m_waddr = m_laps; m_laps++;
      end
    end else if (m_state == "STOP") begin
      if (ss) m_state = "RUN";
      else if (lp) begin
        m_state = "IDLE"; m_clr = 1; m_laps = 0; m_show = 0;
      end else if (sh && m_laps > 0) begin
        m_state = "REVIEW"; m_show = 0; m_scroll = 0;
      end
    end else begin
      if (ss) m_state = "RUN";
      else if (lp) m_state = "STOP";
      else if (sh || (tk && m_scroll == STICKS - 1)) begin
        m_show = (m_show + 1) % m_laps; m_scroll = 0;
      end else if (tk) m_scroll++;
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".mode"},       int'(mode),       mode_of(m_state));
    check({tag, ".run"},        int'(run),        int'(m_state == "RUN"));
    check({tag, ".show_valid"}, int'(show_valid), int'(m_state == "REVIEW"));
    check({tag, ".lap_we"},     int'(lap_we),     m_we);
    check({tag, ".cnt_clr"},    int'(cnt_clr),    m_clr);
    check({tag, ".lap_waddr"},  int'(lap_waddr),  m_waddr);
    check({tag, ".lap_count"},  int'(lap_count),  m_laps);
    check({tag, ".full"},       int'(full),       int'(m_laps == NLAPS));
    check({tag, ".show_addr"},  int'(show_addr),  m_show);
  endtask

  task automatic apply(input bit ss, input bit lp, input bit sh, input bit tk);
    @(negedge clk);
    start_stop_p = ss; lap_p = lp; show_p = sh; tick = tk;
    @(posedge clk);
    model_step(ss, lp, sh, tk);
    #1;
    start_stop_p = 1'b0; lap_p = 1'b0; show_p = 1'b0; tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start_stop_p = 1'b0; lap_p = 1'b0; show_p = 1'b0; tick = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    check_model("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit ss, lp, sh, tk;
    int run, mode, we, waddr, cnt, valid, saddr, clr;
  } vec_t;

  function automatic vec_t mk(input int ss, lp, sh, tk, r, md, we, wa, c, v, sa, cl);
    vec_t x;
    x.ss = ss[0]; x.lp = lp[0]; x.sh = sh[0]; x.tk = tk[0];
    x.run = r; x.mode = md; x.we = we; x.waddr = wa; x.cnt = c;
    x.valid = v; x.saddr = sa; x.clr = cl;
    return x;
  endfunction

  vec_t tbl[18];

  initial begin
    int we_cnt;
    int seq[4];

    //        ss lp sh tk  run md we wa cnt val sa clr
    tbl[0]  = mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0,  1, 1, 1, 0, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 1,  1, 1, 0, 0, 1, 0, 0, 0);
    tbl[5]  = mk(0, 1, 1, 0,  1, 1, 1, 1, 2, 0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 0,  1, 1, 0, 1, 2, 0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0,  0, 2, 0, 1, 2, 0, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0,  0, 3, 0, 1, 2, 1, 0, 0);
    tbl[9]  = mk(0, 0, 1, 0,  0, 3, 0, 1, 2, 1, 1, 0);
    tbl[10] = mk(0, 0, 1, 1,  0, 3, 0, 1, 2, 1, 0, 0);
    tbl[11] = mk(0, 1, 0, 0,  0, 2, 0, 1, 2, 0, 0, 0);
    tbl[12] = mk(0, 0, 1, 0,  0, 3, 0, 1, 2, 1, 0, 0);
    tbl[13] = mk(0, 0, 1, 0,  0, 3, 0, 1, 2, 1, 1, 0);
    tbl[14] = mk(1, 0, 0, 0,  1, 1, 0, 1, 2, 0, 1, 0);
    tbl[15] = mk(1, 0, 0, 0,  0, 2, 0, 1, 2, 0, 1, 0);
    tbl[16] = mk(0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0, 1);
    tbl[17] = mk(0, 0, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0);

    model_reset();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      string t;
      t = $sformatf("tbl%0d", i);
      apply(tbl[i].ss, tbl[i].lp, tbl[i].sh, tbl[i].tk);
      check({t, ".run"},       int'(run),        tbl[i].run);
      check({t, ".mode"},      int'(mode),       tbl[i].mode);
      check({t, ".lap_we"},    int'(lap_we),     tbl[i].we);
      check({t, ".lap_waddr"}, int'(lap_waddr),  tbl[i].waddr);
      check({t, ".lap_count"}, int'(lap_count),  tbl[i].cnt);
      check({t, ".full"},      int'(full),       int'(tbl[i].cnt == NLAPS));
      check({t, ".show_val"},  int'(show_valid), tbl[i].valid);
      check({t, ".show_addr"}, int'(show_addr),  tbl[i].saddr);
      check({t, ".cnt_clr"},   int'(cnt_clr),    tbl[i].clr);
    end

    // Six laps in RUN: only four writes, then saturation.
    do_reset();
    apply(1, 0, 0, 0);
    we_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      apply(0, 1, 0, 0);
      if (lap_we) begin
        check("sat.waddr", int'(lap_waddr), we_cnt);
        we_cnt++;
      end
      apply(0, 0, 0, 0);
      check("sat.we_single", int'(lap_we), 0);
    end
    check("sat.we_count", we_cnt, 4);
    check("sat.lap_count", int'(lap_count), 4);
    check("sat.full", int'(full), 1);

    // Manual review wrap with two laps.
    do_reset();
    apply(1, 0, 0, 0); apply(0, 1, 0, 0); apply(0, 1, 0, 0); apply(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 1, 0);
      seq[i] = int'(show_addr);
    end
    check("wrap.s0", seq[0], 0); check("wrap.s1", seq[1], 1);
    check("wrap.s2", seq[2], 0); check("wrap.s3", seq[3], 1);
    check("wrap.mode", int'(mode), 3);
    check("wrap.valid", int'(show_valid), 1);

    // Clear from STOP, then show ignored in IDLE.
    apply(0, 1, 0, 0);
    check("clr.stop_mode", int'(mode), 2);
    apply(0, 1, 0, 0);
    check("clr.pulse", int'(cnt_clr), 1);
    check("clr.mode", int'(mode), 0);
    check("clr.lap_count", int'(lap_count), 0);
    apply(0, 0, 1, 0);
    check("clr.pulse_end", int'(cnt_clr), 0);
    check("clr.show_ignored", int'(mode), 0);
    check_model("clr");

    // Auto scroll with three laps.
    do_reset();
    apply(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 0);
    apply(1, 0, 0, 0); apply(0, 0, 1, 0);
    for (int i = 1; i <= 40; i++) begin
      apply(0, 0, 0, 1);
      if (i == 19) check("scroll.t19", int'(show_addr), 0);
      if (i == 20) check("scroll.t20", int'(show_addr), 1);
      if (i == 39) check("scroll.t39", int'(show_addr), 1);
      if (i == 40) check("scroll.t40", int'(show_addr), 2);
    end
    apply(0, 0, 1, 0);
    check("scroll.man_wrap", int'(show_addr), 0);
    for (int i = 0; i < 19; i++) apply(0, 0, 0, 1);
    check("scroll.pre_both", int'(show_addr), 0);
    apply(0, 0, 1, 1);
    check("scroll.both_once", int'(show_addr), 1);
    for (int i = 0; i < 19; i++) apply(0, 0, 0, 1);
    check("scroll.restart19", int'(show_addr), 1);
    apply(0, 0, 0, 1);
    check("scroll.restart20", int'(show_addr), 2);
    check_model("scroll");

    // start_stop and lap together in RUN, then reset during REVIEW.
    do_reset();
    apply(1, 0, 0, 0); apply(0, 1, 0, 0);
    apply(1, 1, 0, 0);
    check("prio.mode", int'(mode), 2);
    check("prio.no_we", int'(lap_we), 0);
    check("prio.lap_count", int'(lap_count), 1);
    apply(0, 0, 1, 0);
    check("prio.review", int'(mode), 3);
    do_reset();

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      int busy;
      busy = (i < 1500) ? 8 : 60;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        apply($urandom_range(0, busy * 2) == 0, $urandom_range(0, busy) == 0,
              $urandom_range(0, busy) == 0, $urandom_range(0, 1) == 1);
        check_model($sformatf("rnd%0d", i));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
